// File: rtl/midi_note_parser.sv
// MIDI byte-stream decoder feeding the sine generator: Note On/Off and All Notes Off
// for one channel, monophonic last-note priority. Define MIDI_OMNI_EN to accept all channels.
module midi_note_parser #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [6:0] MIDI_note,
  output logic [6:0] volume,
  output logic       gate,
  output logic       note_strobe
);

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2
  } state_t;

  localparam logic [3:0] LP_NOTE_OFF = 4'h8;
  localparam logic [3:0] LP_NOTE_ON  = 4'h9;
  localparam logic [3:0] LP_CTRL_CHG = 4'hB;
  localparam logic [6:0] LP_ALL_OFF  = 7'd123;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_status, w_status_nxt;
  logic [6:0] r_d1, w_d1_nxt;
  logic [6:0] r_note, w_note_nxt;
  logic [6:0] r_vol, w_vol_nxt;
  logic       r_gate, w_gate_nxt;
  logic       r_strobe, w_strobe_nxt;

  logic       w_is_realtime;
  logic       w_is_system;
  logic       w_is_chan_status;
  logic       w_one_byte;
  logic       w_chan_match;
  logic       w_msg_done;
  logic [6:0] w_msg_d1;
  logic [6:0] w_msg_d2;
  logic [3:0] w_msg_type;

  assign w_is_realtime    = (byte_data[7:3] == 5'b11111);
  assign w_is_system      = (byte_data[7:3] == 5'b11110);
  assign w_is_chan_status = byte_data[7] && (byte_data[7:4] != 4'hF);

  // Program Change (0xC) and Channel Pressure (0xD) carry a single data byte.
  assign w_one_byte = (r_status[7:5] == 3'b110);
  assign w_msg_type = r_status[7:4];

`ifdef MIDI_OMNI_EN
  assign w_chan_match = 1'b1;
`else
  localparam logic [3:0] LP_CHANNEL = 4'(CHANNEL);
  assign w_chan_match = (r_status[3:0] == LP_CHANNEL);
`endif

  // First data byte comes straight off the bus for one-byte messages.
  assign w_msg_d1 = (r_state == WAIT_D1) ? byte_data[6:0] : r_d1;
  assign w_msg_d2 = byte_data[6:0];

  // Byte framing: running status, real-time transparency, system-byte abort.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_d1_nxt     = r_d1;
    w_msg_done   = 1'b0;

    if (byte_valid && !w_is_realtime) begin
      if (w_is_system) begin
        w_state_nxt  = NO_STATUS;
        w_status_nxt = 8'h00;
      end else if (w_is_chan_status) begin
        w_state_nxt  = WAIT_D1;
        w_status_nxt = byte_data;
      end else begin
        unique case (r_state)
          NO_STATUS: w_state_nxt = NO_STATUS;
          WAIT_D1: begin
            w_d1_nxt = byte_data[6:0];
            if (w_one_byte) begin
              w_msg_done = 1'b1;
            end else begin
              w_state_nxt = WAIT_D2;
            end
          end
          WAIT_D2: begin
            w_msg_done  = 1'b1;
            w_state_nxt = WAIT_D1;
          end
          default: w_state_nxt = NO_STATUS;
        endcase
      end
    end
  end

  // Message effect on the note/velocity/gate registers.
  always_comb begin
    w_note_nxt   = r_note;
    w_vol_nxt    = r_vol;
    w_gate_nxt   = r_gate;
    w_strobe_nxt = 1'b0;

    if (w_msg_done && w_chan_match) begin
      if ((w_msg_type == LP_NOTE_ON) && (w_msg_d2 != 7'd0)) begin
        w_note_nxt   = w_msg_d1;
        w_vol_nxt    = w_msg_d2;
        w_gate_nxt   = 1'b1;
        w_strobe_nxt = 1'b1;
      end else if ((w_msg_type == LP_NOTE_OFF) || (w_msg_type == LP_NOTE_ON)) begin
        // Only the currently sounding note can release the gate.
        if (r_gate && (w_msg_d1 == r_note)) begin
          w_gate_nxt   = 1'b0;
          w_strobe_nxt = 1'b1;
        end
      end else if ((w_msg_type == LP_CTRL_CHG) && (w_msg_d1 == LP_ALL_OFF)) begin
        if (r_gate) begin
          w_gate_nxt   = 1'b0;
          w_strobe_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= NO_STATUS;
      r_status <= 8'h00;
      r_d1     <= 7'd0;
      r_note   <= 7'd0;
      r_vol    <= 7'd0;
      r_gate   <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      r_d1     <= w_d1_nxt;
      r_note   <= w_note_nxt;
      r_vol    <= w_vol_nxt;
      r_gate   <= w_gate_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign MIDI_note   = r_note;
  assign volume      = r_vol;
  assign gate        = r_gate;
  assign note_strobe = r_strobe;

endmodule

// File: tb/tb_midi_note_parser.sv
// Self-checking bench for midi_note_parser: directed test-plan steps followed by a
// randomized byte stream, all checked against a message-level reference model.
module tb_midi_note_parser;

  localparam int CH = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [6:0] MIDI_note;
  logic [6:0] volume;
  logic       gate;
  logic       note_strobe;

  midi_note_parser #(.CHANNEL(CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .MIDI_note  (MIDI_note),
    .volume     (volume),
    .gate       (gate),
    .note_strobe(note_strobe)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: running status (-1 = none) plus collected data bytes.
  int m_status;
  int m_data[$];
  int m_note, m_vol, m_gate, m_strobe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = -1;
    m_data.delete();
    m_note = 0; m_vol = 0; m_gate = 0; m_strobe = 0;
  endtask

  function automatic int msg_len(input int st);
    return ((st >> 4) == 12 || (st >> 4) == 13) ? 1 : 2;
  endfunction

  task automatic model_complete();
    int typ, ch, d1, d2;
    bit ok;
    typ = m_status >> 4;
    ch  = m_status & 15;
    d1  = m_data[0];
    d2  = (m_data.size() > 1) ? m_data[1] : 0;
`ifdef MIDI_OMNI_EN
    ok = 1'b1;
`else
    ok = (ch == CH);
`endif
    if (!ok) return;
    if (typ == 9 && d2 != 0) begin
      m_note = d1; m_vol = d2; m_gate = 1; m_strobe = 1;
    end else if ((typ == 8 || typ == 9) && m_gate == 1 && d1 == m_note) begin
      m_gate = 0; m_strobe = 1;
    end else if (typ == 11 && d1 == 123 && m_gate == 1) begin
      m_gate = 0; m_strobe = 1;
    end
  endtask

  task automatic model_byte(input int b);
    m_strobe = 0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_status = -1;
      m_data.delete();
    end else if (b >= 8'h80) begin
      m_status = b;
      m_data.delete();
    end else if (m_status >= 0) begin
      m_data.push_back(b);
      if (m_data.size() == msg_len(m_status)) begin
        model_complete();
        m_data.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_note"},   32'(MIDI_note),   m_note);
    check({tag, "_vol"},    32'(volume),      m_vol);
    check({tag, "_gate"},   32'(gate),        m_gate);
    check({tag, "_strobe"}, 32'(note_strobe), m_strobe);
  endtask

  task automatic send(input int b, input string tag);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b[7:0];
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    model_byte(b);
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      m_strobe = 0;
      check_outputs("idle");
    end
  endtask

  function automatic int rand_byte();
    int r, ch;
    r  = $urandom_range(0, 99);
    ch = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : CH;
    if (r < 45) begin
      case ($urandom_range(0, 4))
        0:       return 0;
        1:       return 123;
        default: return 60 + $urandom_range(0, 3);
      endcase
    end else if (r < 75) begin
      case ($urandom_range(0, 3))
        0:       return 8'h80 | ch;
        3:       return 8'hB0 | ch;
        default: return 8'h90 | ch;
      endcase
    end else if (r < 85) begin
      return ((10 + $urandom_range(0, 3) + ($urandom_range(0, 3) == 3 ? 1 : 0)) << 4 | ch) & 8'hEF;
    end else if (r < 93) begin
      return 8'hF8 + $urandom_range(0, 7);
    end
    return 8'hF0 + $urandom_range(0, 7);
  endfunction

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_reset();
    #5;
    check_outputs("reset");
    #20;
    reset = 1'b1;

    // Basic Note On
    send(8'h90, "on1_s"); send(8'h45, "on1_d1"); send(8'h64, "on1_d2");
    check("on1_note_const", 32'(MIDI_note), 69);
    check("on1_vol_const", 32'(volume), 100);
    idle(1);

    // Running status
    send(8'h90, "rs_s"); send(8'h3C, "rs_d1"); send(8'h40, "rs_d2");
    send(8'h40, "rs2_d1"); send(8'h50, "rs2_d2");
    check("rs_note_const", 32'(MIDI_note), 64);
    check("rs_vol_const", 32'(volume), 80);
    idle(1);

    // Matching Note Off, then non-matching velocity-0 Note On
    send(8'h80, "off_s"); send(8'h40, "off_d1"); send(8'h00, "off_d2");
    check("off_gate_const", 32'(gate), 0);
    check("off_note_const", 32'(MIDI_note), 64);
    send(8'h90, "off2_s"); send(8'h3C, "off2_d1"); send(8'h00, "off2_d2");
    idle(1);

    // Real-time interleave between D1 and D2, then abort + All Notes Off
    send(8'h90, "rt_s"); send(8'h30, "rt_d1"); send(8'hF8, "rt_clk"); send(8'h7F, "rt_d2");
    check("rt_note_const", 32'(MIDI_note), 48);
    check("rt_vol_const", 32'(volume), 127);
    send(8'h90, "ab_s"); send(8'h31, "ab_d1");
    send(8'hB0, "anf_s"); send(8'h7B, "anf_d1"); send(8'h00, "anf_d2");
    check("anf_gate_const", 32'(gate), 0);
    check("anf_note_const", 32'(MIDI_note), 48);
    idle(1);

    // Foreign channel
    send(8'h93, "ch_s"); send(8'h45, "ch_d1"); send(8'h64, "ch_d2");
    idle(1);

    // Async reset in the middle of a message
    send(8'h90, "pre_s"); send(8'h50, "pre_d1"); send(8'h33, "pre_d2");
    send(8'h90, "mid_s"); send(8'h45, "mid_d1");
    @(posedge clk);
    #4;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #3;
    reset = 1'b1;
    send(8'h64, "post_rst_d2");
    idle(1);

    // Randomized stream
    for (int i = 0; i < 800; i++) begin
      send(rand_byte(), "rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Upstream stage of the sine wave generator.
- Consumes raw MIDI bytes from the UART receiver and decodes Note On, Note Off and All Notes Off for one MIDI channel.
- Holds a registered monophonic note/velocity pair that drives the generator's MIDI_freq and volume inputs, plus a gate and an update strobe.
- Tracks running status and tolerates interleaved real-time bytes.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) the parser responds to. Ignored when MIDI_OMNI_EN is defined.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- byte_valid  in  1  one-cycle pulse; byte_data valid this cycle. Always accepted; there is no backpressure.
- byte_data  in  8  received MIDI byte
- MIDI_note  out  7  current note number; feeds the generator's MIDI_freq
- volume  out  7  current note velocity
- gate  out  1  high while a note is held
- note_strobe  out  1  one-cycle pulse when MIDI_note, volume or gate changes due to a decoded message

Behaviour:
- Reset (reset=0, async): MIDI_note=0, volume=0, gate=0, note_strobe=0, FSM=NO_STATUS, running status cleared. Takes effect mid-message; any partial message is discarded.
- Only cycles with byte_valid=1 advance the parser. Inputs are sampled on posedge clk.
- Byte classes:
  - Real-time: 0xF8-0xFF.
  - System: 0xF0-0xF7.
  - Channel status: 0x80-0xEF.
  - Data: 0x00-0x7F.
- Real-time byte: ignored completely. FSM state, running status and partial data are unchanged, even between D1 and D2.
- System byte: clears running status; FSM goes to NO_STATUS. Subsequent data bytes are ignored (SysEx payload dropped).
- Channel status byte: stored as running status. Any partial message is aborted. FSM goes to WAIT_D1.
- Data lengths by status: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn take 2 data bytes; 0xCn, 0xDn take 1. All lengths are parsed so running-status alignment holds even for ignored types.
- FSM states:
  - NO_STATUS: data byte ignored; stay.
  - WAIT_D1: data byte is latched as d1. For 1-byte types, the message completes and FSM stays in WAIT_D1 (running status). Otherwise go to WAIT_D2.
  - WAIT_D2: data byte is d2; the message completes; FSM returns to WAIT_D1 with running status retained.
- Message completion rules apply only if the channel nibble equals CHANNEL; otherwise the message is silently dropped.
  - Note On (0x9n), d2!=0: MIDI_note=d1, volume=d2, gate=1, strobe. This also applies if gate is already high (retrigger / last-note priority).
  - Note On with d2=0: treated as Note Off with velocity 0.
  - Note Off (0x8n, or 0x9n with vel 0): if gate=1 and d1==MIDI_note, then gate=0 and strobe. MIDI_note and volume keep their values. If the note does not match, or gate=0, there is no change and no strobe.
  - CC (0xBn) with d1=123 (All Notes Off), any d2: if gate=1, then gate=0 and strobe; otherwise no change.
  - All other types: no output effect.
- Latency: outputs and note_strobe are registered and update on the clock edge at which the completing data byte is sampled. They are visible in the cycle after byte_valid.
- note_strobe is high for exactly one cycle per effective update and is never asserted on ignored messages.
- Width rules:
  - d1 and d2 are the low 7 bits of byte_data.
  - The channel compare uses byte_data[3:0] of the stored status.

Optional Feature:
- Macro MIDI_OMNI_EN.
- Defined: the channel filter is removed; messages on all 16 channels are decoded and the CHANNEL parameter has no effect.
- Undefined: only messages whose channel equals CHANNEL are acted upon.

Test Plan:
- Reset then 0x90,0x45,0x64 (CHANNEL=0) -> MIDI_note=69, volume=100, gate=1, one note_strobe pulse the cycle after the third byte.
- Running status: 0x90,0x3C,0x40 then 0x40,0x50 -> first sets note 60 / vol 64 / gate=1 with a strobe. The second pair sets note 64 / vol 80 with a second strobe, with no status byte re-sent.
- Note Off matching: note 64 held, send 0x80,0x40,0x00 -> gate=0, strobe, MIDI_note stays 64. Then send 0x90,0x3C,0x00 -> no change, no strobe (gate already 0, note mismatch).
- Real-time interleave and abort:
  - 0x90,0x30,0xF8,0x7F -> note 48, vol 127, gate=1.
  - Then 0x90,0x31 followed by 0xB0,0x7B,0x00 -> the partial Note On is aborted; All Notes Off drives gate=0 with a strobe, and MIDI_note stays 48.
- Channel filter: 0x93,0x45,0x64 -> no output change without MIDI_OMNI_EN. With MIDI_OMNI_EN, note=69, vol=100, gate=1.
- Async reset mid-message: 0x90,0x45 then pulse reset low between clock edges -> outputs go to 0 immediately. A following 0x64 is ignored (NO_STATUS state).
